// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 collecting multiplexer with a registered, source-tagged output beat.
// Optional macro RR_MUX_STATS_EN adds a saturating 16-bit output handshake counter (beat_count).
module rr_mux_arbiter #(
    parameter int BUS_WIDTH = 8,
    parameter int NB_SEL    = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [(2**NB_SEL)*BUS_WIDTH-1:0]    in_data,
    input  logic [(2**NB_SEL)-1:0]              in_valid,
    output logic [(2**NB_SEL)-1:0]              in_ready,
    output logic [BUS_WIDTH-1:0]                out_data,
    output logic [NB_SEL-1:0]                   out_sel,
    output logic                                out_valid,
    input  logic                                out_ready
`ifdef RR_MUX_STATS_EN
    ,
    output logic [15:0]                         beat_count
`endif
);

    localparam int N = 2**NB_SEL;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [BUS_WIDTH-1:0]   r_out_data;
    logic [NB_SEL-1:0]      r_out_sel;
    logic [NB_SEL-1:0]      r_last_grant;

    logic [NB_SEL-1:0]      w_grant;
    logic                   w_found;
    logic                   w_any_req;
    logic                   w_load;
    logic                   w_xfer;
    logic [BUS_WIDTH-1:0]   w_chan [N];

    // Output register can take a new beat when empty or when the current one leaves this cycle.
    assign w_any_req = |in_valid;
    assign w_load    = !rst && ((r_state == ST_EMPTY) || out_ready);
    assign w_xfer    = w_load && w_any_req;

    // Scan starts just past the last granted channel; k == N wraps back onto last_grant itself.
    always_comb begin
        logic [NB_SEL-1:0] v_idx;
        w_grant = '0;
        w_found = 1'b0;
        v_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            v_idx = r_last_grant + NB_SEL'(k);
            if (!w_found && in_valid[v_idx]) begin
                w_grant = v_idx;
                w_found = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign w_chan[gi]   = in_data[gi*BUS_WIDTH +: BUS_WIDTH];
            assign in_ready[gi] = w_xfer && (w_grant == NB_SEL'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_xfer) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_xfer) begin
                    w_state_next = ST_FULL;
                end else if (out_ready) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // Data and tag hold on drain and stall; only a transfer (or reset) changes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data   <= '0;
            r_out_sel    <= '0;
            r_last_grant <= NB_SEL'(N - 1);
        end else if (w_xfer) begin
            r_out_data   <= w_chan[w_grant];
            r_out_sel    <= w_grant;
            r_last_grant <= w_grant;
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = (r_state == ST_FULL);

`ifdef RR_MUX_STATS_EN
    logic [15:0] r_beat_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_count <= '0;
        end else if (out_valid && out_ready && (r_beat_count != 16'hFFFF)) begin
            r_beat_count <= r_beat_count + 16'd1;
        end
    end

    assign beat_count = r_beat_count;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: a cycle model predicts in_ready and pushes expected beats
// to a scoreboard queue, which is popped and compared on every output handshake.
module tb_rr_mux_arbiter;

    localparam int BW = 8;
    localparam int NB = 2;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*BW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [BW-1:0]   out_data;
    logic [NB-1:0]   out_sel;
    logic            out_valid;
    logic            out_ready;
`ifdef RR_MUX_STATS_EN
    logic [15:0]     beat_count;
    int              mdl_cnt;
`endif

    always #5 clk = ~clk;

    rr_mux_arbiter #(.BUS_WIDTH(BW), .NB_SEL(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef RR_MUX_STATS_EN
        ,
        .beat_count(beat_count)
`endif
    );

    typedef struct packed {
        logic [BW-1:0] d;
        logic [NB-1:0] s;
    } beat_t;

    beat_t           sb_q[$];
    int              tests_run    = 0;
    int              tests_failed = 0;
    int              mdl_last;
    bit              mdl_full;
    logic [BW-1:0]   mdl_data;
    logic [NB-1:0]   mdl_sel;
    bit              quiet;

    localparam logic [N*BW-1:0] ALL_DATA = {8'h13, 8'h12, 8'h11, 8'h10};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check 1 time unit later, then advance the model.
    task automatic step(input logic r, input logic [N-1:0] v, input logic [N*BW-1:0] d,
                        input logic ordy);
        bit            load;
        bit            any;
        bit            found;
        int            g;
        int            idx;
        logic [N-1:0]  exp_rdy;
        beat_t         b;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        chk("out_valid", 32'(out_valid), 32'(mdl_full));
        chk("out_data_reg", 32'(out_data), 32'(mdl_data));
        chk("out_sel_reg", 32'(out_sel), 32'(mdl_sel));
        load  = !r && (!mdl_full || ordy);
        any   = |v;
        found = 1'b0;
        g     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (mdl_last + k) % N;
            if (!found && v[idx]) begin
                g     = idx;
                found = 1'b1;
            end
        end
        exp_rdy = (load && any) ? (N'(1) << g) : '0;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (mdl_full && ordy && sb_q.size() > 0) begin
            b = sb_q.pop_front();
            chk("beat_data", 32'(out_data), 32'(b.d));
            chk("beat_sel", 32'(out_sel), 32'(b.s));
            if (!quiet) $display("[TB] beat sel=%0d data=%02h", out_sel, out_data);
        end
`ifdef RR_MUX_STATS_EN
        chk("beat_count", 32'(beat_count), 32'(mdl_cnt));
        if (r) mdl_cnt = 0;
        else if (mdl_full && ordy && mdl_cnt != 65535) mdl_cnt++;
`endif
        if (r) begin
            sb_q.delete();
            mdl_full = 1'b0;
            mdl_last = N - 1;
            mdl_data = '0;
            mdl_sel  = '0;
        end else if (load && any) begin
            mdl_data = d[g*BW +: BW];
            mdl_sel  = NB'(g);
            sb_q.push_back('{d: mdl_data, s: mdl_sel});
            mdl_full = 1'b1;
            mdl_last = g;
        end else if (mdl_full && ordy) begin
            mdl_full = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        mdl_full  = 1'b0;
        mdl_last  = N - 1;
        mdl_data  = '0;
        mdl_sel   = '0;
        quiet     = 1'b0;
`ifdef RR_MUX_STATS_EN
        mdl_cnt   = 0;
`endif

        // Reset with all channels requesting.
        step(1'b1, 4'b1111, ALL_DATA, 1'b1);
        step(1'b1, 4'b1111, ALL_DATA, 1'b1);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_out_sel", 32'(out_sel), 32'h0);

        // Single request on channel 2.
        step(1'b0, 4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 1'b1);
        chk("single_in_ready", 32'(in_ready), 32'h4);
        step(1'b0, 4'b0000, '0, 1'b1);
        chk("single_data", 32'(out_data), 32'hA5);
        chk("single_sel", 32'(out_sel), 32'h2);

        // Fresh reset, then all valid: grants 0,1,2,3,0,1 at one per cycle.
        step(1'b1, 4'b0000, '0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 4'b1111, ALL_DATA, 1'b1);

        // Stall holding the beat from channel 1.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b1111, ALL_DATA, 1'b0);
            chk("stall_data", 32'(out_data), 32'h11);
        end
        step(1'b0, 4'b1111, ALL_DATA, 1'b1);
        chk("resume_grant", 32'(in_ready), 32'h4);
        step(1'b0, 4'b0000, '0, 1'b1);

        // Drain, idle (no priority rotation), then a new request burst.
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, '0, 1'b1);
        step(1'b0, 4'b1011, ALL_DATA, 1'b1);
        chk("idle_no_rotate", 32'(in_ready), 32'h8);

        // Reset while full and inputs valid.
        step(1'b0, 4'b1111, ALL_DATA, 1'b0);
        step(1'b1, 4'b1111, ALL_DATA, 1'b0);
        step(1'b0, 4'b1111, ALL_DATA, 1'b1);
        chk("post_rst_valid", 32'(out_valid), 32'h0);
        chk("post_rst_grant", 32'(in_ready), 32'h1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 40; i++)
            step(1'b0, N'($urandom_range(0, 15)), (N*BW)'($urandom()), 1'($urandom_range(0, 1)));
        step(1'b0, 4'b0000, '0, 1'b1);

`ifdef RR_MUX_STATS_EN
        step(1'b1, 4'b0000, '0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 4'b1111, ALL_DATA, 1'b1);
        step(1'b0, 4'b0000, '0, 1'b1);
        step(1'b0, 4'b0000, '0, 1'b1);
        chk("beat_count_20", 32'(beat_count), 32'd20);
        quiet = 1'b1;
        for (int i = 0; i < 65540; i++) step(1'b0, 4'b1111, ALL_DATA, 1'b1);
        step(1'b0, 4'b0000, '0, 1'b1);
        chk("beat_count_sat", 32'(beat_count), 32'hFFFF);
        quiet = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
